// File: rtl/iterative_alu.sv
// iterative_alu: RV-style ALU with single-cycle base ops and an optional iterative multiply/divide unit.
// Define ITERATIVE_ALU_MULDIV_EN to build the mul/div datapath; without it M ops complete as undefined ops.
package iterative_alu_pkg;
    typedef enum logic [4:0] {
        ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU,
        MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
    } AluOp;
endpackage

module iterative_alu
    import iterative_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_start,
    input  AluOp             i_op,
    input  logic [WIDTH-1:0] i_dataA,
    input  logic [WIDTH-1:0] i_dataB,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result
);
    localparam int SW = $clog2(WIDTH);
`ifdef ITERATIVE_ALU_MULDIV_EN
    typedef enum logic [1:0] {IDLE, CALC, DONE} State;
`else
    typedef enum logic [1:0] {IDLE, DONE} State;
`endif
    State state, nextState;
    logic accept, isMd, lastStep;
    logic [WIDTH-1:0] baseResult, mdResult;
    logic [SW-1:0] shamt;

    assign accept = i_start && !o_busy;
    assign shamt = i_dataB[SW-1:0];

    always_comb begin
        baseResult = '0;
        case (i_op)
            ADD:     baseResult = i_dataA + i_dataB;
            SUB:     baseResult = i_dataA + ~i_dataB + WIDTH'(1);
            AND:     baseResult = i_dataA & i_dataB;
            OR:      baseResult = i_dataA | i_dataB;
            XOR:     baseResult = i_dataA ^ i_dataB;
            SLL:     baseResult = i_dataA << shamt;
            SRL:     baseResult = i_dataA >> shamt;
            SRA:     baseResult = $signed(i_dataA) >>> shamt;
            SLT:     baseResult = {{(WIDTH-1){1'b0}}, $signed(i_dataA) < $signed(i_dataB)};
            SLTU:    baseResult = {{(WIDTH-1){1'b0}}, i_dataA < i_dataB};
            default: baseResult = '0;
        endcase
    end

    always_ff @(posedge i_clock)
        state <= i_reset ? IDLE : nextState;

    always_comb begin
        nextState = state == DONE ? IDLE : state;
`ifdef ITERATIVE_ALU_MULDIV_EN
        if (lastStep) nextState = DONE;
        if (accept) nextState = isMd ? CALC : DONE;
`else
        if (accept) nextState = DONE;
`endif
    end

    always_comb begin
        o_done = state == DONE;
`ifdef ITERATIVE_ALU_MULDIV_EN
        o_busy = state == CALC;
`else
        o_busy = 1'b0;
`endif
    end

    always_ff @(posedge i_clock)
        if (i_reset) o_result <= '0;
        else if (accept && !isMd) o_result <= baseResult;
        else if (lastStep) o_result <= mdResult;

`ifdef ITERATIVE_ALU_MULDIV_EN
    AluOp opReg;
    logic [WIDTH-1:0] hi, lo, operand, stepHi, stepLo, magA, magB;
    logic [WIDTH:0] sum, shifted, diff;
    logic [2*WIDTH-1:0] product;
    logic [SW-1:0] count;
    logic negA, negB, negate, divZero, isDiv;

    assign isMd = i_op inside {MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU};
    assign negA = i_dataA[WIDTH-1] && i_op inside {MULH, MULHSU, DIV, REM};
    assign negB = i_dataB[WIDTH-1] && i_op inside {MULH, DIV};
    assign magA = negA ? -i_dataA : i_dataA;
    assign magB = negB ? -i_dataB : i_dataB;
    assign isDiv = opReg inside {DIV, DIVU, REM, REMU};
    assign lastStep = state == CALC && count == SW'(WIDTH - 1);
    // Multiply shifts {hi,lo} right adding operand into hi; divide shifts left with hi as partial remainder.
    assign sum = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);
    assign shifted = {hi, lo[WIDTH-1]};
    assign diff = shifted - {1'b0, operand};
    assign stepHi = isDiv ? (diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0]) : sum[WIDTH:1];
    assign stepLo = isDiv ? {lo[WIDTH-2:0], ~diff[WIDTH]} : {sum[0], lo[WIDTH-1:1]};
    assign product = negate ? -{stepHi, stepLo} : {stepHi, stepLo};
    // A zero divisor yields an all-ones magnitude quotient; only the signed sign fix-up must be bypassed.
    assign mdResult = opReg == MUL ? product[WIDTH-1:0]
                    : opReg inside {MULH, MULHSU, MULHU} ? product[2*WIDTH-1:WIDTH]
                    : opReg inside {DIV, DIVU} ? (divZero ? '1 : negate ? -stepLo : stepLo)
                    : negate ? -stepHi : stepHi;

    always_ff @(posedge i_clock)
        if (i_reset) begin
            opReg <= ADD;
            hi <= '0;
            lo <= '0;
            operand <= '0;
            count <= '0;
            negate <= 1'b0;
            divZero <= 1'b0;
        end else if (accept && isMd) begin
            opReg <= i_op;
            hi <= '0;
            lo <= magA;
            operand <= magB;
            count <= '0;
            negate <= i_op == REM ? negA : negA ^ negB;
            divZero <= i_dataB == '0;
        end else if (state == CALC) begin
            hi <= stepHi;
            lo <= stepLo;
            count <= count + SW'(1);
        end
`else
    assign isMd = 1'b0;
    assign lastStep = 1'b0;
    assign mdResult = '0;
`endif
endmodule

// File: tb/tb_iterative_alu.sv
// tb_iterative_alu: directed and randomized checks of iterative_alu against a behavioural model.
// Follows ITERATIVE_ALU_MULDIV_EN so the model matches whichever build is compiled.
module tb_iterative_alu;
    import iterative_alu_pkg::*;
`ifdef ITERATIVE_ALU_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, busy, done;
    AluOp op = ADD;
    logic [31:0] a = '0, b = '0, result;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    iterative_alu dut (
        .i_clock(clk), .i_reset(rst), .i_start(start), .i_op(op),
        .i_dataA(a), .i_dataB(b), .o_busy(busy), .o_done(done), .o_result(result)
    );

    function automatic logic [31:0] refResult(input logic [4:0] code, input logic [31:0] x, input logic [31:0] y);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint unsigned ux = 64'(x);
        longint unsigned uy = 64'(y);
        case (code)
            ADD:    return x + y;
            SUB:    return x - y;
            AND:    return x & y;
            OR:     return x | y;
            XOR:    return x ^ y;
            SLL:    return x << y[4:0];
            SRL:    return x >> y[4:0];
            SRA:    return 32'($signed(x) >>> y[4:0]);
            SLT:    return 32'(sx < sy);
            SLTU:   return 32'(x < y);
`ifdef ITERATIVE_ALU_MULDIV_EN
            MUL:    return 32'(ux * uy);
            MULH:   return 32'((sx * sy) >> 32);
            MULHSU: return 32'((sx * longint'(uy)) >> 32);
            MULHU:  return 32'((ux * uy) >> 32);
            DIV:    return y == 0 ? 32'hFFFFFFFF : 32'(sx / sy);
            DIVU:   return y == 0 ? 32'hFFFFFFFF : x / y;
            REM:    return y == 0 ? x : 32'(sx % sy);
            REMU:   return y == 0 ? x : x % y;
`endif
            default: return 32'h0;
        endcase
    endfunction

    function automatic int latOf(input logic [4:0] code);
        return (MD && code >= MUL && code <= REMU) ? 33 : 1;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 15));
            4: return -32'($urandom_range(1, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // Model: an accepted op finishes latOf() cycles later; the cycles strictly in between are busy.
    int cyc = 0, accAt = -1, doneAt = -1;
    logic [31:0] pend = '0, expResult = '0;
    logic expDone = 1'b0, expBusy = 1'b0, valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            accAt = -1;
            doneAt = -1;
            expResult = '0;
            valid = 1'b1;
        end else if (start && !(cyc > accAt && cyc < doneAt)) begin
            accAt = cyc;
            doneAt = cyc + latOf(op);
            pend = refResult(op, a, b);
        end
        expDone = cyc + 1 == doneAt;
        expBusy = cyc + 1 > accAt && cyc + 1 < doneAt;
        if (expDone) expResult = pend;
        cyc++;
    end

    always @(negedge clk)
        if (valid) begin
            check("o_done", 32'(done), 32'(expDone));
            check("o_busy", 32'(busy), 32'(expBusy));
            check("o_result", result, expResult);
        end

    task automatic runOp(input string name, input AluOp code, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] want, input int lat);
        int n = 1;
        @(negedge clk);
        start = 1'b1;
        op = code;
        a = x;
        b = y;
        @(negedge clk);
        start = 1'b0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({name, " latency"}, 32'(n), 32'(lat));
        check(name, result, want);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("model ADD", refResult(ADD, 5, 7), 12);
        check("model SRA", refResult(SRA, 32'h80000000, 4), 32'hF8000000);
        check("model MULHU", refResult(MULHU, '1, '1), MD ? 32'hFFFFFFFE : 0);
        check("model DIV", refResult(DIV, -32'd7, 2), MD ? 32'hFFFFFFFD : 0);
        check("model REM", refResult(REM, -32'd7, 2), MD ? 32'hFFFFFFFF : 0);
        rst = 1'b0;
        start = 1'b1;
        op = ADD;
        a = 5;
        b = 7;
        @(negedge clk);
        start = 1'b0;
        check("first ADD done", 32'(done), 1);
        check("first ADD result", result, 12);
        runOp("SRA", SRA, 32'h80000000, 4, 32'hF8000000, 1);
        runOp("SUB", SUB, 3, 5, 32'hFFFFFFFE, 1);
        runOp("SLT", SLT, 32'hFFFFFFFF, 1, 1, 1);
        runOp("SLTU", SLTU, 32'hFFFFFFFF, 1, 0, 1);
        runOp("undefined op", AluOp'(5'd25), 9, 9, 0, 1);
        runOp("MULHU", MULHU, '1, '1, MD ? 32'hFFFFFFFE : 0, MD ? 33 : 1);
        runOp("MULH", MULH, -32'd3, 5, MD ? 32'hFFFFFFFF : 0, MD ? 33 : 1);
        runOp("MUL", MUL, -32'd3, 5, MD ? 32'hFFFFFFF1 : 0, MD ? 33 : 1);
        runOp("MUL 3x4", MUL, 3, 4, MD ? 12 : 0, MD ? 33 : 1);
        runOp("MULHSU", MULHSU, -32'd1, 2, MD ? 32'hFFFFFFFF : 0, MD ? 33 : 1);
        runOp("DIVU by 0", DIVU, 100, 0, MD ? 32'hFFFFFFFF : 0, MD ? 33 : 1);
        runOp("REMU by 0", REMU, 100, 0, MD ? 100 : 0, MD ? 33 : 1);
        runOp("DIV ovf", DIV, 32'h80000000, '1, MD ? 32'h80000000 : 0, MD ? 33 : 1);
        runOp("REM ovf", REM, 32'h80000000, '1, 0, MD ? 33 : 1);
        runOp("DIV -7/2", DIV, -32'd7, 2, MD ? 32'hFFFFFFFD : 0, MD ? 33 : 1);
        runOp("REM -7/2", REM, -32'd7, 2, MD ? 32'hFFFFFFFF : 0, MD ? 33 : 1);
        runOp("DIV 7/-2", DIV, 7, -32'd2, MD ? 32'hFFFFFFFD : 0, MD ? 33 : 1);
        runOp("REM 7/-2", REM, 7, -32'd2, MD ? 1 : 0, MD ? 33 : 1);
        // MUL with an ADD pulsed mid-flight, then an ADD issued in the DONE cycle
        @(negedge clk);
        start = 1'b1;
        op = MUL;
        a = 7;
        b = 9;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        start = 1'b1;
        op = ADD;
        a = 1;
        b = 2;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 40 && !done; k++) @(negedge clk);
        check("MUL after ignored ADD", result, MD ? 63 : 3);
        start = 1'b1;
        op = ADD;
        a = 10;
        b = 20;
        @(negedge clk);
        start = 1'b0;
        check("ADD in DONE done", 32'(done), 1);
        check("ADD in DONE result", result, 30);
        // DIV aborted by a one-cycle reset
        @(negedge clk);
        start = 1'b1;
        op = DIV;
        a = 100;
        b = 7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", 32'(busy), 0);
        check("abort result", result, 0);
        repeat (40) @(negedge clk);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst = $urandom_range(0, 299) == 0;
            start = $urandom_range(0, 3) == 0;
            op = AluOp'(5'($urandom_range(0, 22)));
            a = pick();
            b = pick();
        end
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        repeat (40) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
